alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between NREQ requesters (e.g. main datapath, branch/AGU helper,
//  debug port). Round-robin arbiter plus FSM: selects a request, drives the ALU operands for one
//  cycle, registers result and Zero, and returns them tagged with the requester id.
//  The ALU is instantiated outside this block; only its ports connect here.
// PARAMETERS
//  NREQ   2   number of requesters (2..8)
//  W      32  operand/result width
//  IDW    $clog2(NREQ) (min 1)  width of requester id
// PORTS
//  iCLK         in   1         clock; all state on rising edge
//  iRST_n       in   1         asynchronous reset, active-low
//  iReqValid    in   NREQ      per-requester request valid
//  iReqCtrl     in   5*NREQ    per-requester ALU opcode (slice i = [5i+4:5i])
//  iReqA        in   W*NREQ    per-requester operand A
//  iReqB        in   W*NREQ    per-requester operand B
//  oReqReady    out  NREQ      one-hot accept; request i taken when iReqValid[i]&oReqReady[i]
//  oAluCtrl     out  5         to ALU iControl
//  oAluA        out  W         to ALU iA
//  oAluB        out  W         to ALU iB
//  iAluResult   in   W         from ALU oResult
//  iAluZero     in   1         from ALU Zero
//  oRspValid    out  1         response valid
//  oRspId       out  IDW       requester id of response
//  oRspResult   out  W         registered ALU result
//  oRspZero     out  1         registered ALU Zero
//  iRspReady    in   1         response consumer ready
//  oBusy        out  1         1 when state != IDLE
// BEHAVIOUR
//  Reset (iRST_n=0, async): state=IDLE, rr pointer=0, oRspValid=0, oRspId=0, oRspResult=0,
//   oRspZero=0, operand regs=0; oReqReady=0 while reset asserted. Any in-flight op is dropped.
//  States: IDLE -> EXEC on accept; EXEC -> RESP always (1 cycle); RESP -> IDLE on
//   iRspReady with no new accept; RESP -> EXEC on iRspReady with same-cycle accept.
//  Arbitration: among iReqValid bits, grant first index >= pointer, wrapping modulo NREQ.
//   After grant to i, pointer=(i+1)%NREQ. Pointer unchanged when nothing granted.
//  oReqReady: one-hot grant when state==IDLE, or when state==RESP && iRspReady; else 0.
//   oReqReady may depend combinationally on iReqValid; iReqValid must not depend on oReqReady.
//  Accept cycle t: Ctrl/A/B/id of the grantee latched into internal regs.
//  EXEC (t+1): oAluCtrl/A/B driven from latched regs; end of t+1 capture iAluResult,
//   iAluZero into oRspResult/oRspZero, oRspId=latched id, oRspValid=1.
//  Latency accept->oRspValid = 2 cycles; max throughput 1 op per 2 cycles with iRspReady=1.
//  Outside EXEC: oAluCtrl=5'b0, oAluA=0, oAluB=0 (ALU default branch; no toggling).
//  RESP: oRspValid/Id/Result/Zero stable until iRspReady=1; cleared (valid=0) on handshake
//   unless a new op completes later. Opcode not decoded here; invalid opcodes pass through.
//  Fairness: continuously-valid requester granted within NREQ accepts.
//  oBusy=1 in EXEC and RESP.
// TESTING
//  Reset with iReqValid=2'b11 -> oReqReady=0, outputs 0; after release, first grant = req0.
//  Req0 OPADD A=5,B=7, iRspReady=1 -> oReqReady=01 at t, oRspValid at t+2, Result=12, Id=0, Zero=0.
//  Both valid continuously, iRspReady=1 -> grants alternate 0,1,0,1; responses every 2 cycles.
//  Req1 OPSUB A=9,B=9, iRspReady held 0 for 5 cycles -> Result=0, Zero=1 held stable; no new grant.
//  NREQ=3, only req2 valid with pointer=0 -> grant req2, pointer becomes 0 (wrap).
//  Assert iRST_n=0 during EXEC -> immediate IDLE, no oRspValid afterwards for that op.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Purpose: bundles requester, ALU-port and response signals of the shared-ALU arbiter.
// Latency: none (wires only).
// Backpressure: req_rdy per requester, rsp_rdy from the response consumer.
interface alu_share_arbiter_if #(
    parameter int NREQ = 2,
    parameter int W    = 32,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req_vld;
    logic [5*NREQ-1:0] req_ctrl;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_rdy;

    logic [4:0]        alu_ctrl;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [W-1:0]      alu_res;
    logic              alu_zero;

    logic              rsp_vld;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_dat;
    logic              rsp_zero;
    logic              rsp_rdy;

    logic              busy;

    // Arbiter side.
    modport slave (
        input  req_vld, req_ctrl, req_a, req_b,
        input  alu_res, alu_zero,
        input  rsp_rdy,
        output req_rdy,
        output alu_ctrl, alu_a, alu_b,
        output rsp_vld, rsp_id, rsp_dat, rsp_zero,
        output busy
    );

    // Requesters, external ALU and response consumer.
    modport master (
        output req_vld, req_ctrl, req_a, req_b,
        output alu_res, alu_zero,
        output rsp_rdy,
        input  req_rdy,
        input  alu_ctrl, alu_a, alu_b,
        input  rsp_vld, rsp_id, rsp_dat, rsp_zero,
        input  busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one external combinational ALU among NREQ requesters.
// Latency: accept -> rsp_vld in 2 cycles; at most one op per 2 cycles.
// Backpressure: rsp held stable until rsp_rdy; no new grant while a response waits.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 32,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [4:0]     ctrl;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } op_t;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    op_t            op_q, sel_op;

    logic           hi_found, lo_found;
    logic [IDW-1:0] hi_idx, lo_idx;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic           accept_win, accept;

    logic           rsp_vld_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_dat_q;
    logic           rsp_zero_q;

    // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_vld[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(i);
                if (IDW'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
        grant_found = lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        grant_oh = '0;
        sel_op   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_found && (grant_idx == IDW'(i))) begin
                grant_oh[i] = 1'b1;
                sel_op.id   = IDW'(i);
                sel_op.ctrl = bus.req_ctrl[5*i +: 5];
                sel_op.a    = bus.req_a[W*i +: W];
                sel_op.b    = bus.req_b[W*i +: W];
            end
        end
    end

    // rst_n gates the window so no request is acknowledged while reset is held.
    assign accept_win  = rst_n && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_RESP) && bus.rsp_rdy));
    assign accept      = accept_win && grant_found;
    assign bus.req_rdy = accept_win ? grant_oh : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_rdy) state_d = accept ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                op_q <= sel_op;
            end
        end
    end

    // Result is captured at the end of the single EXEC cycle; handshake only drops valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_dat_q  <= '0;
            rsp_zero_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_vld_q  <= 1'b1;
            rsp_id_q   <= op_q.id;
            rsp_dat_q  <= bus.alu_res;
            rsp_zero_q <= bus.alu_zero;
        end else if ((state_q == ST_RESP) && bus.rsp_rdy) begin
            rsp_vld_q  <= 1'b0;
        end
    end

    // Operands are parked at zero outside EXEC so the ALU sits idle in its default branch.
    assign bus.alu_ctrl = (state_q == ST_EXEC) ? op_q.ctrl : 5'd0;
    assign bus.alu_a    = (state_q == ST_EXEC) ? op_q.a    : '0;
    assign bus.alu_b    = (state_q == ST_EXEC) ? op_q.b    : '0;

    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_id   = rsp_id_q;
    assign bus.rsp_dat  = rsp_dat_q;
    assign bus.rsp_zero = rsp_zero_q;
    assign bus.busy     = (state_q != ST_IDLE);
endmodule
